// File: rtl/fb_write_sequencer.sv
// rtl/fb_write_sequencer.sv - frame-buffer write-port sequencer: power-on clear, full clears, brush stamps
module fb_write_sequencer #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 20,
  parameter int MEM_WIDTH  = 640,
  parameter int MEM_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_color,
  input  logic                  stamp_req,
  input  logic [9:0]            cursor_x,
  input  logic [9:0]            cursor_y,
  input  logic [3:0]            brushSize,
  input  logic [DATA_WIDTH-1:0] stamp_color,
  output logic                  ready,
  output logic                  init_done,
  output logic                  clear_done,
  output logic                  stamp_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  localparam logic [ADDR_WIDTH-1:0] TOTAL_PIX  = ADDR_WIDTH'(MEM_WIDTH * MEM_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(MEM_WIDTH);
  localparam logic [9:0]            W_LIM      = 10'(MEM_WIDTH);
  localparam logic [9:0]            H_LIM      = 10'(MEM_HEIGHT);
  localparam logic signed [10:0]    X_MAX      = 11'(MEM_WIDTH - 1);
  localparam logic signed [10:0]    Y_MAX      = 11'(MEM_HEIGHT - 1);

  typedef enum logic [2:0] {INIT, IDLE, CLEAR, STAMP_SETUP, STAMP_RUN} state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
  logic [DATA_WIDTH-1:0]   color_q, color_d;
  logic [9:0]              cx_q, cx_d, cy_q, cy_d;
  logic [3:0]              r_q, r_d;
  logic [9:0]              x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [9:0]              cur_x, cur_x_d, cur_y, cur_y_d;
  logic [ADDR_WIDTH-1:0]   row_base, row_base_d;
  logic                    last_q, last_d;
  logic                    ready_d, init_done_d, clear_done_d, stamp_done_d, we_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   data_d;

  logic signed [10:0]      cx_s, cy_s, r_s, x_lo, x_hi, y_lo, y_hi;
  logic [9:0]              sx0, sx1, sy0, sy1;
  logic                    s_empty;
  logic [ADDR_WIDTH-1:0]   s_base;

  logic                    in_setup;
  logic [9:0]              px, py, bx0, bx1, by1, nx, ny;
  logic [ADDR_WIDTH-1:0]   pbase, nbase, pix_addr;
  logic                    nlast;

  // Clipped stamp rectangle from the latched cursor and radius
  always_comb begin
    cx_s    = $signed({1'b0, cx_q});
    cy_s    = $signed({1'b0, cy_q});
    r_s     = $signed({7'b0, r_q});
    x_lo    = cx_s - r_s;
    x_hi    = cx_s + r_s;
    y_lo    = cy_s - r_s;
    y_hi    = cy_s + r_s;
    sx0     = x_lo[10] ? 10'd0 : x_lo[9:0];
    sy0     = y_lo[10] ? 10'd0 : y_lo[9:0];
    sx1     = (x_hi > X_MAX) ? X_MAX[9:0] : x_hi[9:0];
    sy1     = (y_hi > Y_MAX) ? Y_MAX[9:0] : y_hi[9:0];
    s_empty = (cx_q >= W_LIM) || (cy_q >= H_LIM);
    s_base  = ADDR_WIDTH'(sy0) * ROW_STRIDE;
  end

  // Current stamp pixel and its row-major successor; setup uses fresh bounds, run uses latched ones
  always_comb begin
    in_setup = (state == STAMP_SETUP);
    px       = in_setup ? sx0 : cur_x;
    py       = in_setup ? sy0 : cur_y;
    pbase    = in_setup ? s_base : row_base;
    bx0      = in_setup ? sx0 : x0_q;
    bx1      = in_setup ? sx1 : x1_q;
    by1      = in_setup ? sy1 : y1_q;
    pix_addr = pbase + ADDR_WIDTH'(px);
    nx       = px;
    ny       = py;
    nbase    = pbase;
    nlast    = 1'b0;
    if (px != bx1) begin
      nx = px + 10'd1;
    end else if (py != by1) begin
      nx    = bx0;
      ny    = py + 10'd1;
      nbase = pbase + ROW_STRIDE;
    end else begin
      nlast = 1'b1;
    end
  end

  // Next-state and registered-output values; outputs hold unless a write or pulse is issued
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    color_d      = color_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    r_d          = r_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    cur_x_d      = cur_x;
    cur_y_d      = cur_y;
    row_base_d   = row_base;
    last_d       = last_q;
    ready_d      = 1'b0;
    init_done_d  = init_done;
    clear_done_d = 1'b0;
    stamp_done_d = 1'b0;
    we_d         = 1'b0;
    addr_d       = mem_write_addr;
    data_d       = mem_write_data;
    case (state)
      INIT: begin
        if (cnt == TOTAL_PIX) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt;
          data_d = '1;
          cnt_d  = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          color_d = clear_color;
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = clear_color;
          cnt_d   = ADDR_WIDTH'(1);
        end else if (stamp_req) begin
          color_d = stamp_color;
          cx_d    = cursor_x;
          cy_d    = cursor_y;
          r_d     = brushSize;
          state_d = STAMP_SETUP;
        end else begin
          ready_d = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == TOTAL_PIX) begin
          state_d      = IDLE;
          ready_d      = 1'b1;
          clear_done_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt;
          data_d = color_q;
          cnt_d  = cnt + 1'b1;
        end
      end
      STAMP_SETUP: begin
        if (s_empty) begin
          state_d      = IDLE;
          ready_d      = 1'b1;
          stamp_done_d = 1'b1;
        end else begin
          state_d    = STAMP_RUN;
          x0_d       = sx0;
          x1_d       = sx1;
          y1_d       = sy1;
          we_d       = 1'b1;
          addr_d     = pix_addr;
          data_d     = color_q;
          cur_x_d    = nx;
          cur_y_d    = ny;
          row_base_d = nbase;
          last_d     = nlast;
        end
      end
      STAMP_RUN: begin
        if (last_q) begin
          state_d      = IDLE;
          ready_d      = 1'b1;
          stamp_done_d = 1'b1;
        end else begin
          we_d       = 1'b1;
          addr_d     = pix_addr;
          data_d     = color_q;
          cur_x_d    = nx;
          cur_y_d    = ny;
          row_base_d = nbase;
          last_d     = nlast;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State, working registers and registered outputs; reset restarts the power-on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT;
      cnt            <= '0;
      color_q        <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      r_q            <= '0;
      x0_q           <= '0;
      x1_q           <= '0;
      y1_q           <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      row_base       <= '0;
      last_q         <= 1'b0;
      ready          <= 1'b0;
      init_done      <= 1'b0;
      clear_done     <= 1'b0;
      stamp_done     <= 1'b0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '1;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      color_q        <= color_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      r_q            <= r_d;
      x0_q           <= x0_d;
      x1_q           <= x1_d;
      y1_q           <= y1_d;
      cur_x          <= cur_x_d;
      cur_y          <= cur_y_d;
      row_base       <= row_base_d;
      last_q         <= last_d;
      ready          <= ready_d;
      init_done      <= init_done_d;
      clear_done     <= clear_done_d;
      stamp_done     <= stamp_done_d;
      mem_we         <= we_d;
      mem_write_addr <= addr_d;
      mem_write_data <= data_d;
    end
  end

endmodule

// File: tb/tb_fb_write_sequencer.sv
// tb/tb_fb_write_sequencer.sv - directed bench for fb_write_sequencer on a 640x16 buffer
module tb_fb_write_sequencer;

  localparam int DW = 3;
  localparam int AW = 20;
  localparam int W = 640;
  localparam int H = 16;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic [DW-1:0] clear_color = '0;
  logic          stamp_req = 1'b0;
  logic [9:0]    cursor_x = '0;
  logic [9:0]    cursor_y = '0;
  logic [3:0]    brushSize = '0;
  logic [DW-1:0] stamp_color = '0;
  logic          ready, init_done, clear_done, stamp_done, mem_we;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;

  fb_write_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WIDTH(W), .MEM_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst),
    .clear_req(clear_req), .clear_color(clear_color),
    .stamp_req(stamp_req), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .brushSize(brushSize), .stamp_color(stamp_color),
    .ready(ready), .init_done(init_done), .clear_done(clear_done), .stamp_done(stamp_done),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_s = 1'b1;
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int n_clear_done = 0, n_stamp_done = 0;
  int clear_done_cyc = -1, stamp_done_cyc = -1, init_rise_cyc = -1;
  logic init_prev = 1'b0;
  int bound_viol = 0, hold_viol = 0;
  logic have_prev = 1'b0;
  int prev_addr = 0, prev_data = 0;

  typedef struct {int cx; int cy; int r; int col; int x0; int x1; int y0; int y1;} vec_t;
  vec_t vecs[9];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_write_addr));
      wd_q.push_back(int'(mem_write_data));
      wc_q.push_back(cyc);
      if (int'(mem_write_addr) >= TOTAL) bound_viol++;
    end else if (!rst_s && have_prev &&
                 (int'(mem_write_addr) != prev_addr || int'(mem_write_data) != prev_data)) begin
      hold_viol++;
    end
    prev_addr = int'(mem_write_addr);
    prev_data = int'(mem_write_data);
    have_prev = 1'b1;
    if (clear_done) begin n_clear_done++; clear_done_cyc = cyc; end
    if (stamp_done) begin n_stamp_done++; stamp_done_cyc = cyc; end
    if (init_done && !init_prev) init_rise_cyc = cyc;
    init_prev = init_done;
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  // Expected writes: row-major over the given rectangle, one per cycle from first_cyc
  task automatic check_writes(input string tag, input int first_cyc, input int col,
                              input int x0, input int x1, input int y0, input int y1);
    int n, bad, late, idx;
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    check_eq($sformatf("%s_count", tag), wa_q.size(), n);
    bad = 0; late = 0; idx = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (idx < wa_q.size()) begin
          if (wa_q[idx] != y * W + x || wd_q[idx] != col) bad++;
          if (wc_q[idx] != first_cyc + idx) late++;
        end
        idx++;
      end
    end
    if (n > 0) begin
      check_eq($sformatf("%s_content", tag), bad, 0);
      check_eq($sformatf("%s_timing", tag), late, 0);
    end
  endtask

  task automatic do_stamp(input int cx, input int cy, input int r, input int col, output int t);
    int n0;
    clear_log();
    n0 = n_stamp_done;
    cursor_x = 10'(cx); cursor_y = 10'(cy); brushSize = 4'(r); stamp_color = 3'(col);
    stamp_req = 1'b1;
    t = cyc;
    check_eq("stamp_accept_ready", ready, 1);
    tick();
    stamp_req = 1'b0;
    for (int i = 0; i < 2000 && n_stamp_done == n0; i++) tick();
    check_eq("stamp_done_pulses", n_stamp_done - n0, 1);
  endtask

  initial begin
    int t, t2, n, n_s0, n_c0;
    vecs[0] = '{100, 10, 2, 4, 98, 102, 8, 12};
    vecs[1] = '{0, 0, 3, 2, 0, 3, 0, 3};
    vecs[2] = '{639, 15, 1, 1, 638, 639, 14, 15};
    vecs[3] = '{700, 5, 2, 3, 0, -1, 0, 0};
    vecs[4] = '{640, 5, 0, 3, 0, -1, 0, 0};
    vecs[5] = '{10, 16, 4, 3, 0, -1, 0, 0};
    vecs[6] = '{5, 7, 0, 6, 5, 5, 7, 7};
    vecs[7] = '{639, 0, 15, 5, 624, 639, 0, 15};
    vecs[8] = '{20, 8, 15, 3, 5, 35, 0, 15};

    repeat (3) tick();
    check_eq("rst_ready", ready, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_clear_done", clear_done, 0);
    check_eq("rst_stamp_done", stamp_done, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_addr", mem_write_addr, 0);
    check_eq("rst_data", mem_write_data, 7);

    // Power-on clear to white
    clear_log();
    rst = 1'b0;
    t = cyc;
    for (int i = 0; i < TOTAL + 50 && init_rise_cyc < 0; i++) tick();
    check_eq("init_done_seen", init_rise_cyc >= 0, 1);
    check_writes("init", t + 1, 7, 0, W - 1, 0, H - 1);
    check_eq("init_done_cycle", init_rise_cyc, t + TOTAL + 1);
    check_eq("init_ready", ready, 1);

    // Stamp table
    for (int k = 0; k < 9; k++) begin
      do_stamp(vecs[k].cx, vecs[k].cy, vecs[k].r, vecs[k].col, t);
      n = (vecs[k].x1 - vecs[k].x0 + 1) * (vecs[k].y1 - vecs[k].y0 + 1);
      check_writes($sformatf("stamp%0d", k), t + 2, vecs[k].col,
                   vecs[k].x0, vecs[k].x1, vecs[k].y0, vecs[k].y1);
      check_eq($sformatf("stamp%0d_done_cycle", k), stamp_done_cyc, t + 2 + n);
      check_eq($sformatf("stamp%0d_ready", k), ready, 1);
    end

    // Explicit spot checks of the centre stamp endpoints
    do_stamp(100, 10, 2, 4, t);
    check_eq("centre_first_addr", wa_q.size() > 0 ? wa_q[0] : -1, 5218);
    check_eq("centre_last_addr", wa_q.size() > 0 ? wa_q[wa_q.size() - 1] : -1, 7782);
    check_eq("centre_row_stride", wa_q.size() > 5 ? wa_q[5] - wa_q[0] : -1, 640);

    // New stamp accepted in the same cycle as the previous stamp_done
    clear_log();
    n_s0 = n_stamp_done;
    cursor_x = 10'd5; cursor_y = 10'd3; brushSize = 4'd0; stamp_color = 3'd5;
    stamp_req = 1'b1;
    t = cyc;
    tick();
    stamp_req = 1'b0;
    for (int i = 0; i < 10 && cyc < t + 3; i++) tick();
    check_eq("b2b_done_high", stamp_done, 1);
    check_eq("b2b_ready_high", ready, 1);
    check_eq("b2b_first_count", wa_q.size(), 1);
    check_eq("b2b_first_addr", wa_q.size() > 0 ? wa_q[0] : -1, 1925);
    check_eq("b2b_first_cycle", wc_q.size() > 0 ? wc_q[0] : -1, t + 2);
    clear_log();
    cursor_x = 10'd6; cursor_y = 10'd3; brushSize = 4'd1; stamp_color = 3'd2;
    stamp_req = 1'b1;
    t2 = cyc;
    tick();
    stamp_req = 1'b0;
    for (int i = 0; i < 100 && n_stamp_done < n_s0 + 2; i++) tick();
    check_eq("b2b_done_pulses", n_stamp_done - n_s0, 2);
    check_writes("b2b_second", t2 + 2, 2, 5, 7, 2, 4);
    check_eq("b2b_second_done_cycle", stamp_done_cyc, t2 + 2 + 9);

    // Clear and stamp together: clear wins; a stamp while busy is ignored
    clear_log();
    n_s0 = n_stamp_done;
    n_c0 = n_clear_done;
    clear_color = 3'd0; stamp_color = 3'd7;
    cursor_x = 10'd100; cursor_y = 10'd10; brushSize = 4'd2;
    clear_req = 1'b1; stamp_req = 1'b1;
    t = cyc;
    check_eq("both_accept_ready", ready, 1);
    tick();
    clear_req = 1'b0; stamp_req = 1'b0;
    repeat (100) tick();
    check_eq("busy_ready_low", ready, 0);
    stamp_req = 1'b1;
    tick();
    stamp_req = 1'b0;
    for (int i = 0; i < TOTAL + 100 && n_clear_done == n_c0; i++) tick();
    repeat (5) tick();
    check_eq("clear_done_pulses", n_clear_done - n_c0, 1);
    check_writes("clear", t + 1, 0, 0, W - 1, 0, H - 1);
    check_eq("clear_done_cycle", clear_done_cyc, t + TOTAL + 1);
    check_eq("clear_no_stamp_done", n_stamp_done - n_s0, 0);
    check_eq("clear_ready", ready, 1);

    // Reset in the middle of a clear
    clear_log();
    n_c0 = n_clear_done;
    clear_color = 3'd2;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 2000 && wa_q.size() < 1000; i++) tick();
    check_eq("midclr_reached", wa_q.size() >= 1000, 1);
    check_eq("midclr_data", wd_q.size() > 0 ? wd_q[wd_q.size() - 1] : -1, 2);
    rst = 1'b1;
    tick();
    check_eq("midclr_we_low", mem_we, 0);
    check_eq("midclr_ready_low", ready, 0);
    check_eq("midclr_init_low", init_done, 0);
    tick();
    init_rise_cyc = -1;
    clear_log();
    rst = 1'b0;
    t = cyc;
    for (int i = 0; i < TOTAL + 50 && init_rise_cyc < 0; i++) tick();
    repeat (3) tick();
    check_writes("reinit", t + 1, 7, 0, W - 1, 0, H - 1);
    check_eq("reinit_done_cycle", init_rise_cyc, t + TOTAL + 1);
    check_eq("reinit_no_clear_done", n_clear_done - n_c0, 0);

    check_eq("addr_bound_viol", bound_viol, 0);
    check_eq("hold_viol", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_sequencer.md
# fb_write_sequencer

Write-port controller for the 640x480 frame-buffer BRAM. It owns the single BRAM write port and sequences all writes to it: an automatic power-on clear to white, operator-requested full-screen clears, and square brush stamps around the cursor, one write per clock. Higher-level paint logic only issues one-cycle requests. It never drives per-pixel video-scan writes. The VGA read path is unaffected.

## Interface
- DATA_WIDTH, 3, pixel colour width ({R,G,B})
- ADDR_WIDTH, 20, BRAM address width
- MEM_WIDTH, 640, pixels per row
- MEM_HEIGHT, 480, rows
- clk  in  1  system clock; single clock domain, everything on rising edge
- rst  in  1  synchronous, active-high reset
- clear_req  in  1  request a full-screen clear; accepted only when ready=1
- clear_color  in  DATA_WIDTH  fill colour, sampled on acceptance
- stamp_req  in  1  request a brush stamp; accepted only when ready=1
- cursor_x  in  10  stamp centre column, sampled on acceptance
- cursor_y  in  10  stamp centre row, sampled on acceptance
- brushSize  in  4  stamp radius r (0..15); side is 2r+1
- stamp_color  in  DATA_WIDTH  stamp colour, sampled on acceptance
- ready  out  1  high only in IDLE
- init_done  out  1  low until the power-on clear finishes, then stays high until rst
- clear_done  out  1  one-cycle pulse after the last write of a requested clear
- stamp_done  out  1  one-cycle pulse after a stamp completes
- mem_we  out  1  BRAM write enable
- mem_write_addr  out  ADDR_WIDTH  BRAM write address
- mem_write_data  out  DATA_WIDTH  BRAM write data

## Operation
- States: INIT, IDLE, CLEAR, STAMP_SETUP, STAMP_RUN.
- Reset values: state=INIT, ready=0, init_done=0, clear_done=0, stamp_done=0, mem_we=0, mem_write_addr=0, mem_write_data=all ones.
- INIT: writes all ones (white) to addresses 0..W*H-1 in ascending order, one per cycle.
  - After the last write: init_done=1, go to IDLE.
  - No done pulse is issued for INIT.
- IDLE, request acceptance: a request is accepted on a cycle where the request is high and ready=1.
  - If clear_req and stamp_req are both high, clear wins and the stamp is dropped. Nothing is queued.
  - Requests that arrive while ready=0 are ignored.
- CLEAR: writes the latched clear_color to addresses 0..W*H-1, ascending. Then pulse clear_done and return to IDLE.
- STAMP_SETUP: one cycle. Computes the clipped bounds with 11-bit signed arithmetic:
  - x0=max(0,cx-r), x1=min(W-1,cx+r)
  - y0=max(0,cy-r), y1=min(H-1,cy+r)
  - If cx>=W or cy>=H, the region is empty: no writes, pulse stamp_done, go to IDLE.
- STAMP_RUN: walks the region row-major, y0..y1 outer and x0..x1 inner. Writes addr = y*W + x with the latched stamp_color.
  - Row base is built incrementally (start y0*W, add W per row). No runtime multiplier except the one-time y0*W.
- Write count: clears issue exactly W*H writes; stamps issue exactly (x1-x0+1)*(y1-y0+1).
- Address bounds: mem_write_addr never exceeds W*H-1.
- Outputs are registered. mem_write_addr and mem_write_data hold their last value when mem_we=0.

## Timing
- Throughput: one write per cycle. mem_we stays high continuously for the whole sequence, with no gaps.
- Power-on: the first INIT write appears in the first cycle after rst deasserts. init_done rises the cycle after the last write.
- Clear accepted in cycle T: writes occupy cycles T+1..T+W*H. clear_done=1 and ready=1 in cycle T+W*H+1.
- Stamp accepted in cycle T: STAMP_SETUP occupies T+1, and writes occupy T+2..T+1+N. stamp_done=1 and ready=1 in cycle T+2+N.
- Empty stamp: stamp_done=1 and ready=1 in cycle T+2.
- A new request is accepted in the same cycle a done pulse is high.
- rst mid-sequence: mem_we=0 in the cycle after the reset edge and the operation is abandoned. After release, INIT restarts from address 0 and no done pulse is emitted for the aborted operation.

## Test plan
- Power-on: release rst -> 307200 consecutive writes of 3'b111 at addresses 0..307199; init_done rises the next cycle; ready=1.
- Centre stamp: cursor (100,50), r=2, colour 3'b100 -> 25 writes. First address 30818, row stride 640, last address 33382. stamp_done follows 1 cycle after the last write.
- Corner clip: cursor (0,0), r=3 -> 16 writes at 0..3, 640..643, 1280..1283, 1920..1923.
- Far-corner clip: cursor (639,479), r=1 -> 4 writes at 306558, 306559, 307198, 307199.
- Simultaneous requests and empty stamp:
  - clear_req and stamp_req in the same cycle with clear_color=3'b000 -> only the clear runs (307200 writes of 0); stamp_done never pulses.
  - stamp at cursor_x=700 -> zero writes, stamp_done in T+2.
- Reset mid-clear: assert rst after 1000 clear writes -> mem_we=0 the next cycle, no clear_done, then INIT restarts from address 0 with colour 3'b111.
